// File: rtl/string_stream_processor.sv
// Store-and-forward character stream engine. It collects one string of up to
// MAX_LEN characters and then replays it with a per-string transform:
// passthrough, upper-case, lower-case or reverse.
// Characters beyond MAX_LEN are dropped, and the overflow output pulses when
// the string closes. CHAR_W must be at least 8; only the low byte is
// case-mapped.
module string_stream_processor #(
    parameter int unsigned CHAR_W  = 8,
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_data,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_len,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LOWER = 2'd2;
    localparam logic [1:0] MODE_REV   = 2'd3;

    typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

    state_e             r_state, w_state_d;
    logic [LEN_W-1:0]   r_count, w_count_d;
    logic [LEN_W-1:0]   r_beat, w_beat_d;
    logic [1:0]         r_mode, w_mode_d;
    logic               r_trunc, w_trunc_d;
    logic               r_overflow, w_overflow_d;

    logic [CHAR_W-1:0]  r_buf [MAX_LEN];

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_full;
    logic               w_final_beat;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0]  w_rd_addr;

    // Case mapping on the low byte; upper bits of wide characters pass through.
    function automatic logic [CHAR_W-1:0] f_xform(input logic [CHAR_W-1:0] c,
                                                  input logic [1:0]        m);
        logic [CHAR_W-1:0] res;
        res = c;
        if (m == MODE_UPPER && c[7:0] >= 8'h61 && c[7:0] <= 8'h7A) begin
            res[7:0] = c[7:0] - 8'h20;
        end else if (m == MODE_LOWER && c[7:0] >= 8'h41 && c[7:0] <= 8'h5A) begin
            res[7:0] = c[7:0] + 8'h20;
        end
        return res;
    endfunction

    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = out_valid && out_ready;
    assign w_full       = (r_count == MAX_CNT);
    assign w_final_beat = (r_beat == r_count - ONE);

    // Reverse mode walks the stored string from the top down.
    assign w_rd_addr = ADDR_W'((r_mode == MODE_REV) ? (r_count - ONE - r_beat) : r_beat);

    // Next-state, buffer write control and outputs.
    always_comb begin
        w_state_d    = r_state;
        w_count_d    = r_count;
        w_beat_d     = r_beat;
        w_mode_d     = r_mode;
        w_trunc_d    = r_trunc;
        w_overflow_d = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = ADDR_W'(r_count);

        in_ready  = (r_state != StEmit);
        out_valid = (r_state == StEmit);
        busy      = (r_state != StIdle);
        out_last  = (r_state == StEmit) && w_final_beat;
        out_len   = (r_state == StEmit) ? r_count : '0;
        // Gated so stale buffer contents never reach the output.
        out_data  = (r_state == StEmit) ? f_xform(r_buf[w_rd_addr], r_mode) : '0;

        unique case (r_state)
            StIdle: begin
                if (w_in_fire) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = '0;
                    w_mode_d  = mode;
                    w_count_d = ONE;
                    w_trunc_d = 1'b0;
                    w_beat_d  = '0;
                    w_state_d = in_last ? StEmit : StCollect;
                end
            end
            StCollect: begin
                if (w_in_fire) begin
                    if (!w_full) begin
                        w_wr_en   = 1'b1;
                        w_count_d = r_count + ONE;
                    end else begin
                        w_trunc_d = 1'b1;
                    end
                    if (in_last) begin
                        // Includes a drop caused by the closing character itself.
                        w_overflow_d = r_trunc || w_full;
                        w_beat_d     = '0;
                        w_state_d    = StEmit;
                    end
                end
            end
            StEmit: begin
                if (w_out_fire) begin
                    if (w_final_beat) begin
                        w_state_d = StIdle;
                        w_count_d = '0;
                        w_beat_d  = '0;
                        w_trunc_d = 1'b0;
                    end else begin
                        w_beat_d = r_beat + ONE;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_beat     <= '0;
            r_mode     <= '0;
            r_trunc    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_beat     <= w_beat_d;
            r_mode     <= w_mode_d;
            r_trunc    <= w_trunc_d;
            r_overflow <= w_overflow_d;
        end
    end

    // Character storage; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= in_data;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_string_stream_processor.sv
// Bench for string_stream_processor: two instances (MAX_LEN 32 and 4) share
// one stimulus stream. A string-level model predicts every output beat.
module tb_string_stream_processor;

    localparam int ML0 = 32;
    localparam int ML1 = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [7:0] len;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic [1:0] ir, ov, ol, ovf, bz;
    logic [7:0] od [2];
    logic [5:0] len32;
    logic [2:0] len4;

    int n_chk = 0;
    int n_pass = 0;
    bit bp_en = 1'b0;
    bit gap_en = 1'b0;

    // String-level model state, one slot per instance.
    beat_t      exp_q [2][$];
    logic [7:0] cur [2][$];
    logic [7:0] log_q [2][$];
    logic [1:0] cur_mode [2];
    bit         inprog [2];
    bit         ovf_exp [2];

    string_stream_processor #(.CHAR_W(8), .MAX_LEN(ML0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_last(ol[0]), .out_len(len32), .overflow(ovf[0]), .busy(bz[0])
    );

    string_stream_processor #(.CHAR_W(8), .MAX_LEN(ML1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_last(ol[1]), .out_len(len4), .overflow(ovf[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    endtask

    task automatic fail_tmo(input string nm);
        n_chk++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic int maxl(input int i);
        return (i == 0) ? ML0 : ML1;
    endfunction

    function automatic logic [7:0] xf(input logic [7:0] c, input logic [1:0] m);
        if (m == 2'd1 && c inside {[8'h61:8'h7A]}) return c - 8'h20;
        if (m == 2'd2 && c inside {[8'h41:8'h5A]}) return c + 8'h20;
        return c;
    endfunction

    // Expected beats of a closed string: first MAX_LEN chars, transformed, maybe reversed.
    task automatic close_str(input int i);
        int n, k, src;
        beat_t b;
        n = cur[i].size();
        k = (n > maxl(i)) ? maxl(i) : n;
        for (int j = 0; j < k; j++) begin
            src = (cur_mode[i] == 2'd3) ? k - 1 - j : j;
            b.d = xf(cur[i][src], cur_mode[i]);
            b.last = (j == k - 1);
            b.len = 8'(k);
            exp_q[i].push_back(b);
        end
        ovf_exp[i] = (n > maxl(i));
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int alen;
            alen = (i == 0) ? int'(len32) : int'(len4);
            if (!rst_n) begin
                chk($sformatf("dut%0d reset in_ready", i), int'(ir[i]), 1);
                chk($sformatf("dut%0d reset out_valid", i), int'(ov[i]), 0);
                chk($sformatf("dut%0d reset out_data", i), int'(od[i]), 0);
                chk($sformatf("dut%0d reset out_last", i), int'(ol[i]), 0);
                chk($sformatf("dut%0d reset out_len", i), alen, 0);
                chk($sformatf("dut%0d reset overflow", i), int'(ovf[i]), 0);
                chk($sformatf("dut%0d reset busy", i), int'(bz[i]), 0);
                exp_q[i].delete();
                cur[i].delete();
                inprog[i] = 1'b0;
                ovf_exp[i] = 1'b0;
            end else begin
                chk($sformatf("dut%0d in_ready", i), int'(ir[i]), int'(exp_q[i].size() == 0));
                chk($sformatf("dut%0d out_valid", i), int'(ov[i]), int'(exp_q[i].size() != 0));
                chk($sformatf("dut%0d busy", i), int'(bz[i]),
                    int'(inprog[i] || exp_q[i].size() != 0));
                chk($sformatf("dut%0d overflow", i), int'(ovf[i]), int'(ovf_exp[i]));
                ovf_exp[i] = 1'b0;
                if (ov[i] && exp_q[i].size() != 0) begin
                    chk($sformatf("dut%0d out_data", i), int'(od[i]), int'(exp_q[i][0].d));
                    chk($sformatf("dut%0d out_last", i), int'(ol[i]), int'(exp_q[i][0].last));
                    chk($sformatf("dut%0d out_len", i), alen, int'(exp_q[i][0].len));
                    if (out_ready) begin
                        log_q[i].push_back(od[i]);
                        void'(exp_q[i].pop_front());
                    end
                end
                if (in_valid && ir[i]) begin
                    if (!inprog[i]) begin
                        cur_mode[i] = mode;
                        cur[i].delete();
                        inprog[i] = 1'b1;
                    end
                    cur[i].push_back(in_data);
                    if (in_last) begin
                        close_str(i);
                        inprog[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Downstream acceptance, optionally random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input logic lst, input logic [1:0] m);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = c;
        in_last = lst;
        mode = m;
        for (int t = 0; t < 3000 && !acc; t++) begin
            @(negedge clk);
            acc = ir[0] && ir[1];
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) fail_tmo("send_char");
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                mode = 2'($urandom);
                tick();
            end
        end
    endtask

    // Later characters carry a random mode, which must be ignored.
    task automatic send_str(input string s, input logic [1:0] m, input int upto);
        for (int k = 0; k < upto; k++) begin
            send_char(s[k], (k == s.len() - 1), (k == 0) ? m : 2'($urandom));
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        in_valid = 1'b0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || inprog[0] || inprog[1])
               && t < 5000) begin
            tick();
            t++;
        end
        if (t >= 5000) fail_tmo("wait_idle");
        tick();
    endtask

    task automatic chk_log(input int i, input string s);
        chk($sformatf("dut%0d string length '%s'", i, s), log_q[i].size(), s.len());
        for (int k = 0; k < s.len() && k < log_q[i].size(); k++) begin
            chk($sformatf("dut%0d '%s' char %0d", i, s, k), int'(log_q[i][k]), int'(s[k]));
        end
        log_q[i].delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] m;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        send_str("abc", 2'd0, 3);
        wait_idle();
        chk_log(0, "abc");
        chk_log(1, "abc");

        send_str("Hi z!", 2'd1, 5);
        wait_idle();
        chk_log(0, "HI Z!");
        chk_log(1, "HI Z");

        send_str("ABc9", 2'd2, 4);
        wait_idle();
        chk_log(0, "abc9");
        chk_log(1, "abc9");

        send_str("abcd", 2'd3, 4);
        wait_idle();
        chk_log(0, "dcba");
        chk_log(1, "dcba");

        send_str("abcdef", 2'd0, 6);
        wait_idle();
        chk_log(0, "abcdef");
        chk_log(1, "abcd");

        send_str("wxyz", 2'd0, 4);
        wait_idle();
        chk_log(0, "wxyz");
        chk_log(1, "wxyz");

        bp_en = 1'b1;
        gap_en = 1'b1;
        send_str("abcdefghijklmnopqrst", 2'd3, 20);
        wait_idle();
        chk_log(0, "tsrqponmlkjihgfedcba");
        chk_log(1, "dcba");

        // Reset in the middle of a string discards it.
        gap_en = 1'b0;
        send_str("hello", 2'd0, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_idle();
        send_str("ok", 2'd0, 2);
        wait_idle();
        chk_log(0, "ok");
        chk_log(1, "ok");

        // 'R' is held on the input while 'q' is emitted.
        bp_en = 1'b0;
        send_str("Q", 2'd2, 1);
        send_str("R", 2'd1, 1);
        wait_idle();
        chk_log(0, "qR");
        chk_log(1, "qR");

        for (int s = 0; s < 40; s++) begin
            bp_en = 1'($urandom);
            gap_en = 1'($urandom);
            n = $urandom_range(1, 40);
            m = 2'($urandom);
            for (int k = 0; k < n; k++) begin
                send_char(8'($urandom_range(32, 126)), (k == n - 1), (k == 0) ? m : 2'($urandom));
            end
            wait_idle();
            log_q[0].delete();
            log_q[1].delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
